// File: rtl/pwm_duty_if.sv
//------------------------------------------------------------------------------
// Module   : pwm_duty_if
// Brief    : Pulse-width measurement inputs and duty-cycle results for pwm_duty_calc.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pwm_duty_if #(
    parameter int DUTY_W = 16
);
    logic [30:0]       pw_high;
    logic [30:0]       pw_low;
    logic [31:0]       pwm_per;
    logic [DUTY_W-1:0] duty;
    logic              duty_valid;
    logic              busy;
    logic              div_zero;

    // master is the measurement side, slave is the duty calculator
    modport master (
        output pw_high, pw_low, pwm_per,
        input  duty, duty_valid, busy, div_zero
    );

    modport slave (
        input  pw_high, pw_low, pwm_per,
        output duty, duty_valid, busy, div_zero
    );
endinterface

`default_nettype wire

// File: rtl/pwm_duty_calc.sv
//------------------------------------------------------------------------------
// Module   : pwm_duty_calc
// Brief    : Duty = floor(pw_high*2^DUTY_W/pwm_per) via serial restoring division.
//            Optional output smoothing selected by macro PWM_DUTY_AVG_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pwm_duty_calc #(
    parameter int DUTY_W = 16
) (
    input  wire logic   clk,
    input  wire logic   reset,
    pwm_duty_if.slave   bus
);

    localparam int              c_CNT_W = $clog2(DUTY_W);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DUTY_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic [93:0]        r_cap;
    logic [32:0]        r_rem;
    logic [DUTY_W-1:0]  r_quot;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sat;
    logic [DUTY_W-1:0]  r_duty;
    logic               r_duty_valid;
    logic               r_div_zero;

    logic [93:0]        w_in;
    logic               w_change;
    logic               w_per_zero;
    logic [32:0]        w_shift;
    logic [33:0]        w_sub;
    logic               w_qbit;
    logic [32:0]        w_rem_nxt;
    logic [DUTY_W-1:0]  w_q;
    logic [DUTY_W-1:0]  w_duty_nxt;
    logic               w_unused_rem_msb;

    assign w_in       = {bus.pw_high, bus.pw_low, bus.pwm_per};
    // X on an input makes this compare X, so the IDLE branch is not taken
    assign w_change   = (w_in != r_cap);
    assign w_per_zero = (bus.pwm_per == 32'd0);

    // Remainder stays below the divisor (< 2^32), so its top bit is always clear
    assign w_shift          = {r_rem[31:0], 1'b0};
    assign w_sub            = {1'b0, w_shift} - {2'b00, r_cap[31:0]};
    assign w_qbit           = ~w_sub[33];
    assign w_rem_nxt        = w_qbit ? w_sub[32:0] : w_shift;
    assign w_unused_rem_msb = r_rem[32];

    assign w_q = r_sat ? {DUTY_W{1'b1}} : r_quot;

`ifdef PWM_DUTY_AVG_EN
    logic                r_first;
    logic signed [DUTY_W:0] w_delta;
    logic signed [DUTY_W:0] w_avg;

    assign w_delta    = $signed({1'b0, w_q}) - $signed({1'b0, r_duty});
    assign w_avg      = $signed({1'b0, r_duty}) + (w_delta >>> 2);
    assign w_duty_nxt = r_first ? w_q : w_avg[DUTY_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_first <= 1'b1;
        end else if (r_state == S_DONE) begin
            r_first <= 1'b0;
        end
    end
`else
    assign w_duty_nxt = w_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_change && !w_per_zero) w_state_nxt = S_CALC;
            S_CALC: if (r_cnt == c_LAST)         w_state_nxt = S_DONE;
            S_DONE:                              w_state_nxt = S_IDLE;
            default:                             w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap        <= '0;
            r_rem        <= '0;
            r_quot       <= '0;
            r_cnt        <= '0;
            r_sat        <= 1'b0;
            r_duty       <= '0;
            r_duty_valid <= 1'b0;
            r_div_zero   <= 1'b0;
        end else begin
            r_duty_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_change) begin
                        r_cap      <= w_in;
                        r_div_zero <= w_per_zero;
                        r_rem      <= {2'b00, bus.pw_high};
                        r_quot     <= '0;
                        r_cnt      <= '0;
                        r_sat      <= ({1'b0, bus.pw_high} >= bus.pwm_per);
                    end
                end
                S_CALC: begin
                    r_rem  <= w_rem_nxt;
                    r_quot <= {r_quot[DUTY_W-2:0], w_qbit};
                    r_cnt  <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    r_duty       <= w_duty_nxt;
                    r_duty_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.duty       = r_duty;
    assign bus.duty_valid = r_duty_valid;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.div_zero   = r_div_zero;

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_calc.sv
//------------------------------------------------------------------------------
// Module   : tb_pwm_duty_calc
// Brief    : Self-checking bench for pwm_duty_calc against an arithmetic model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pwm_duty_calc;

    localparam int DW = 16;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    logic [DW-1:0] model_duty;
    logic          model_first;

    pwm_duty_if #(.DUTY_W(DW)) bus ();

    pwm_duty_calc #(.DUTY_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Exact fraction, saturated when the high time is not below the period
    function automatic logic [DW-1:0] raw_q(input logic [30:0] ph, input logic [31:0] per);
        longint unsigned num;
        if (64'(ph) >= 64'(per)) return {DW{1'b1}};
        num = 64'(ph) << DW;
        return DW'(num / 64'(per));
    endfunction

    function automatic logic [DW-1:0] next_model(input logic [DW-1:0] q);
`ifdef PWM_DUTY_AVG_EN
        longint d;
        if (model_first) return q;
        d = (longint'(q) - longint'(model_duty)) >>> 2;
        return DW'(longint'(model_duty) + d);
`else
        return q;
`endif
    endfunction

    task automatic wait_strobe(output int cycles, output int busy_n);
        cycles = 0;
        busy_n = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (bus.duty_valid === 1'b1) break;
            if (bus.busy === 1'b1) busy_n++;
        end
    endtask

    task automatic apply(input logic [30:0] ph, input logic [30:0] pl, input logic [31:0] per);
        @(negedge clk);
        bus.pw_high = ph;
        bus.pw_low  = pl;
        bus.pwm_per = per;
    endtask

    task automatic run_txn(input string tag, input logic [30:0] ph, input logic [30:0] pl,
                           input logic [31:0] per);
        int k;
        int busy_n;
        apply(ph, pl, per);
        @(posedge clk); #1;
        check({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
        wait_strobe(k, busy_n);
        check({tag, "_latency"}, 64'(k), 64'(DW + 1));
        check({tag, "_busy_cycles"}, 64'(busy_n + 1), 64'(DW + 1));
        model_duty  = next_model(raw_q(ph, per));
        model_first = 1'b0;
        check({tag, "_duty"}, 64'(bus.duty), 64'(model_duty));
        check({tag, "_div_zero"}, 64'(bus.div_zero), 64'd0);
        @(posedge clk); #1;
        check({tag, "_strobe_width"}, 64'(bus.duty_valid), 64'd0);
    endtask

    initial begin
        int k;
        int busy_n;
        int strobes;
        logic [30:0] ph;
        logic [31:0] per;

        n_checks    = 0;
        n_errors    = 0;
        model_duty  = '0;
        model_first = 1'b1;
        reset       = 1'b1;
        bus.pw_high = '0;
        bus.pw_low  = '0;
        bus.pwm_per = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_duty",     64'(bus.duty),       64'd0);
        check("rst_valid",    64'(bus.duty_valid), 64'd0);
        check("rst_busy",     64'(bus.busy),       64'd0);
        check("rst_div_zero", 64'(bus.div_zero),   64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_txn("p12_16", 31'd12, 31'd4, 32'd16);
        run_txn("p1_3",   31'd1,  31'd2, 32'd3);
        run_txn("p0_10",  31'd0,  31'd10, 32'd10);
        run_txn("sat_gt", 31'd20, 31'd0, 32'd16);
        run_txn("sat_eq", 31'd8,  31'd0, 32'd8);
        run_txn("p12_again", 31'd12, 31'd4, 32'd16);

        // Zero period: flag set, result held, no strobe
        apply(31'd5, 31'd5, 32'd0);
        @(posedge clk); #1;
        check("zero_div_zero", 64'(bus.div_zero), 64'd1);
        check("zero_busy",     64'(bus.busy),     64'd0);
        strobes = 0;
        repeat (DW + 4) begin
            @(posedge clk); #1;
            if (bus.duty_valid === 1'b1) strobes++;
        end
        check("zero_no_strobe", 64'(strobes), 64'd0);
        check("zero_duty_hold", 64'(bus.duty), 64'(model_duty));
        run_txn("p4_16", 31'd4, 31'd12, 32'd16);

        for (int i = 0; i < 12; i++) begin
            ph  = 31'($urandom) >> $urandom_range(0, 30);
            per = $urandom >> $urandom_range(0, 31);
            if (per == 32'd0) per = 32'd1;
            run_txn($sformatf("rnd%0d", i), ph, 31'(per - 32'(ph)), per);
        end

        // Inputs change at CALC cycle 5: old result first, then the new one
        apply(31'd12, 31'd4, 32'd16);
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        bus.pw_high = 31'd8;
        bus.pw_low  = 31'd8;
        bus.pwm_per = 32'd16;
        wait_strobe(k, busy_n);
        check("mid_first_latency", 64'(k + 5), 64'(DW + 1));
        model_duty = next_model(raw_q(31'd12, 32'd16));
        check("mid_first_duty", 64'(bus.duty), 64'(model_duty));
        wait_strobe(k, busy_n);
        check("mid_second_spacing", 64'(k), 64'(DW + 2));
        model_duty = next_model(raw_q(31'd8, 32'd16));
        check("mid_second_duty", 64'(bus.duty), 64'(model_duty));

        // Reset at CALC cycle 3 aborts the division
        apply(31'd3, 31'd1, 32'd4);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        reset       = 1'b1;
        bus.pw_high = '0;
        bus.pw_low  = '0;
        bus.pwm_per = '0;
        @(posedge clk); #1;
        reset       = 1'b0;
        model_duty  = '0;
        model_first = 1'b1;
        check("abort_duty",     64'(bus.duty),       64'd0);
        check("abort_valid",    64'(bus.duty_valid), 64'd0);
        check("abort_busy",     64'(bus.busy),       64'd0);
        check("abort_div_zero", 64'(bus.div_zero),   64'd0);
        strobes = 0;
        busy_n  = 0;
        repeat (DW + 6) begin
            @(posedge clk); #1;
            if (bus.duty_valid === 1'b1) strobes++;
            if (bus.busy === 1'b1) busy_n++;
        end
        check("abort_no_strobe", 64'(strobes), 64'd0);
        check("abort_no_busy",   64'(busy_n),  64'd0);

        run_txn("post_rst", 31'd8, 31'd8, 32'd16);
        run_txn("post_rst2", 31'd0, 31'd16, 32'd16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
